// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths, FSM state and operation encodings for the line memory interface
package mem_if_pkg;
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 28;
  typedef enum logic [1:0] {MR_IDLE = 2'd0, MR_BUSY = 2'd1, MR_RESP = 2'd2} mr_state_e;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} mem_op_e;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: single-port synchronous line storage with registered read data, no reset so it maps to block RAM
module mem_line_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] idx,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);
  logic [LINE_W-1:0] mem_q [0:(1<<DEPTH_W)-1];
  // one access per cycle: write the line or register the addressed line onto rdata
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    if (re) rdata <= mem_q[idx];
  end
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency 128-bit line memory; MEM_PROTO_CHECK_EN adds the sticky proto_err checker
module mem_line_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int DEPTH_W = 10
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready
`ifdef MEM_PROTO_CHECK_EN
  ,
  output logic                  proto_err
`endif
);
  mr_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0]     wdata_q, arr_rdata;
  mem_op_e               op_q;
  logic                  ready_q, rvalid_q, accept, done, unused_hi;
  assign unused_hi = ^addr_q[MEM_ADDR_W-1:DEPTH_W];
  // next state: accept in IDLE, count down in BUSY, single RESP cycle ignoring inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      MR_IDLE: if (mem_read | mem_write) begin
        state_d = MR_BUSY;
        cnt_d   = 8'(LATENCY - 1);
        accept  = 1'b1;
      end
      MR_BUSY: if (cnt_q == 8'd0) begin
        state_d = MR_RESP;
        done    = 1'b1;
      end else cnt_d = cnt_q - 8'd1;
      MR_RESP: state_d = MR_IDLE;
      default: state_d = MR_IDLE;
    endcase
  end
  // control state; rvalid_q keeps mem_rdata at zero from reset until the first read lands
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q  <= MR_IDLE;
      cnt_q    <= 8'd0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= done;
      if (done && op_q == OP_RD) rvalid_q <= 1'b1;
    end
  end
  // request latches; write wins when both request bits are high
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      op_q    <= mem_write ? OP_WR : OP_RD;
    end
  end
  mem_line_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk  (clk),
    .we   (done && op_q == OP_WR),
    .re   (done && op_q == OP_RD),
    .idx  (addr_q[DEPTH_W-1:0]),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );
  assign mem_ready = ready_q;
  assign mem_rdata = rvalid_q ? arr_rdata : '0;
`ifdef MEM_PROTO_CHECK_EN
  logic rd_q, wr_q, err_q;
  // latched request bits so held-request violations can be seen during BUSY
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q <= mem_read;
      wr_q <= mem_write;
    end
  end
  // sticky error: read+write together, or request/address/data not held stable while BUSY
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) err_q <= 1'b0;
    else if ((mem_read & mem_write) ||
             (state_q == MR_BUSY && (mem_addr != addr_q || mem_wdata != wdata_q ||
                                     mem_read != rd_q || mem_write != wr_q)))
      err_q <= 1'b1;
  end
  assign proto_err = err_q;
`endif
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: two responders (LATENCY 8 / DEPTH_W 10 and LATENCY 1 / DEPTH_W 4) on shared inputs vs a timeline model
module tb_mem_line_responder;
  logic         clk = 1'b0, proc_reset = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] rd8, rd1;
  logic         rdy8, rdy1;
  logic         err8, err1;
  int           nchk = 0, nerr = 0, tcyc = 0;
  bit           chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  mem_line_responder #(.LATENCY(8), .DEPTH_W(10)) dut8 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rd8), .mem_ready(rdy8)
`ifdef MEM_PROTO_CHECK_EN
    , .proto_err(err8)
`endif
  );
  mem_line_responder #(.LATENCY(1), .DEPTH_W(4)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rd1), .mem_ready(rdy1)
`ifdef MEM_PROTO_CHECK_EN
    , .proto_err(err1)
`endif
  );
`ifndef MEM_PROTO_CHECK_EN
  assign err8 = 1'b0;
  assign err1 = 1'b0;
`endif

  function automatic int lat_of(int d);
    return d == 0 ? 8 : 1;
  endfunction
  function automatic int mask_of(int d);
    return d == 0 ? 1023 : 15;
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, got, exp, tcyc);
    end
  endtask

  // timeline model: accepted at edge a, completes at a+L, inputs ignored at a+L+1
  logic [127:0] mm [2][1024];
  bit           mk [2][1024];
  bit           act[2], opw[2], lrd[2], lwr[2];
  int           acc[2];
  logic [27:0]  la[2];
  logic [127:0] lw[2];
  bit           e_rdy[2], e_rk[2], e_err[2];
  logic [127:0] e_rd[2];

  always @(posedge clk or posedge proc_reset) begin
    for (int d = 0; d < 2; d++) begin
      if (proc_reset) begin
        act[d] = 0; e_rdy[d] = 0; e_rd[d] = '0; e_rk[d] = 1; e_err[d] = 0;
      end else begin
        int ix;
        ix = int'(la[d]) & mask_of(d);
        e_rdy[d] = 0;
        if (mem_read && mem_write) e_err[d] = 1;
        if (act[d] && tcyc > acc[d] && tcyc <= acc[d] + lat_of(d) &&
            (mem_addr != la[d] || mem_wdata != lw[d] || mem_read != lrd[d] || mem_write != lwr[d]))
          e_err[d] = 1;
        if (act[d] && tcyc == acc[d] + lat_of(d)) begin
          if (opw[d]) begin mm[d][ix] = lw[d]; mk[d][ix] = 1; end
          else begin e_rd[d] = mm[d][ix]; e_rk[d] = mk[d][ix]; end
          e_rdy[d] = 1;
        end else if (act[d] && tcyc == acc[d] + lat_of(d) + 1) act[d] = 0;
        else if (!act[d] && (mem_read || mem_write)) begin
          act[d] = 1; acc[d] = tcyc; opw[d] = mem_write;
          la[d] = mem_addr; lw[d] = mem_wdata; lrd[d] = mem_read; lwr[d] = mem_write;
        end
      end
    end
  end

  // per-cycle comparison of both responders against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready8", 128'(rdy8), 128'(e_rdy[0]));
      chk("ready1", 128'(rdy1), 128'(e_rdy[1]));
      if (e_rk[0]) chk("rdata8", rd8, e_rd[0]);
      if (e_rk[1]) chk("rdata1", rd1, e_rd[1]);
`ifdef MEM_PROTO_CHECK_EN
      chk("err8", 128'(err8), 128'(e_err[0]));
      chk("err1", 128'(err1), 128'(e_err[1]));
`endif
    end
  end

  task automatic drive(bit r, bit w, logic [27:0] a, logic [127:0] d);
    mem_read = r; mem_write = w; mem_addr = a; mem_wdata = d;
  endtask

  // waits for a ready pulse on responder d; returns the clock edge at which it rose
  task automatic wait_rdy(int d, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((d == 0 ? rdy8 : rdy1) === 1'b1) begin
        t = tcyc - 1;
        return;
      end
    end
    nchk++; nerr++;
    $display("FAIL timeout dut%0d: no ready within 40 cycles (t=%0d)", d, tcyc);
  endtask

  task automatic xact8(bit r, bit w, logic [27:0] a, logic [127:0] d, output int lat);
    int k, t;
    drive(r, w, a, d);
    k = tcyc;
    wait_rdy(0, t);
    lat = t - k;
  endtask

  localparam logic [127:0] D_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D_B = 128'hDEADBEEF_00000000_CAFEF00D_11111111;
  localparam logic [127:0] D_C = 128'h5A5A5A5A_A5A5A5A5_12345678_87654321;
  localparam logic [127:0] D_D = 128'hFEEDFACE_0BADC0DE_99999999_77777777;
  localparam logic [127:0] D_E = 128'h00000000_00000000_00000000_0000BEEF;
  localparam logic [127:0] D_F = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;

  initial begin
    int lat, k, t1, t2;
    logic [31:0] u;
    bit r, w;
    #1 proc_reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset ready8", 128'(rdy8), 128'd0);
    chk("reset ready1", 128'(rdy1), 128'd0);
    chk("reset rdata8", rd8, 128'd0);
    chk("reset rdata1", rd1, 128'd0);
    @(negedge clk);
    proc_reset = 1'b0;
    @(negedge clk);
    // write then read line 3, 8-cycle latency each, one-cycle pulse
    xact8(0, 1, 28'h3, D_A, lat);
    chk("wr latency", 128'(lat), 128'd8);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("pulse width", 128'(rdy8), 128'd0);
    xact8(1, 0, 28'h3, '0, lat);
    chk("rd latency", 128'(lat), 128'd8);
    chk("rd data", rd8, D_A);
    drive(0, 0, 0, 0);
    @(negedge clk);
    // write-back immediately followed by allocate: pulses L+2 edges apart
    drive(0, 1, 28'hA, D_B);
    wait_rdy(0, t1);
    drive(1, 0, 28'hB, '0);
    wait_rdy(0, t2);
    chk("wb-alloc spacing", 128'(t2 - t1), 128'd10);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    // latency-1 responder: ready one edge after acceptance, re-acceptance three edges later
    xact8(0, 1, 28'h7, D_C, lat);
    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    drive(1, 0, 28'h7, '0);
    k = tcyc;
    wait_rdy(1, t1);
    chk("lat1 latency", 128'(t1 - k), 128'd1);
    chk("lat1 data", rd1, D_C);
    wait_rdy(1, t2);
    chk("lat1 reaccept", 128'(t2 - t1), 128'd3);
    wait_rdy(0, t1);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    // address aliasing above DEPTH_W
    xact8(0, 1, 28'h400, D_D, lat);
    drive(0, 0, 0, 0);
    @(negedge clk);
    xact8(1, 0, 28'h0, '0, lat);
    chk("alias data", rd8, D_D);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    // reset in the middle of a write: no pulse, old contents survive
    xact8(0, 1, 28'h5, D_E, lat);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(0, 1, 28'h5, D_F);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 proc_reset = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("reset mid ready", 128'(rdy8), 128'd0);
    chk("reset mid rdata", rd8, 128'd0);
    @(negedge clk);
    proc_reset = 1'b0;
    repeat (2) @(negedge clk);
    xact8(1, 0, 28'h5, '0, lat);
    chk("post-reset rd", rd8, D_E);
    drive(0, 0, 0, 0);
    @(negedge clk);
    // randomized traffic held as the cache holds it
    for (int i = 0; i < 40; i++) begin
      u = $urandom;
      r = u[31];
      w = !r;
      if (u[30:27] == 4'd0) begin r = 1; w = 1; end
      drive(r, w, {u[27:10], 6'd0, u[3:0]}, {$urandom, $urandom, $urandom, $urandom});
      wait_rdy(0, t1);
      k = $urandom_range(0, 3);
      if (k > 0) begin
        drive(0, 0, 0, 0);
        repeat (k) @(negedge clk);
      end
    end
    drive(0, 0, 0, 0);
    repeat (12) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0d)", tcyc);
    $fatal(1);
  end
endmodule
